// File: rtl/divrem_pipe.sv
// Pipelined radix-2^BASE divider for DIV/DIVU/REM/REMU with tag carry and flush.
// Digit stages are registered every PERIOD stages; the sign/zero fix-up is combinational after the last register.
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif

module divrem_pipe #(
  parameter int unsigned W      = 32,
  parameter int unsigned BASE   = 4,
  parameter int unsigned PERIOD = 3,
  parameter int unsigned TAG_W  = `LEN_PREG_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             order,
  output logic             accepted,
  output logic             done,
  input  logic [W-1:0]     rs1,
  input  logic [W-1:0]     rs2,
  input  logic [1:0]       mode,
  input  logic             flush,
  input  logic [TAG_W-1:0] pa_rd_in,
  output logic [W-1:0]     rd,
  output logic [TAG_W-1:0] pa_rd_out
);

  localparam int unsigned N  = W / BASE;
  localparam int unsigned K  = (1 << BASE) - 1;
  localparam int unsigned RW = W + BASE;
  // meta = {is_rem, dz, neg_r, neg_q, raw rs1, tag}; travels unchanged after stage 0
  localparam int unsigned MW = 4 + W + TAG_W;

  assign accepted = order & ~flush & ~rst;

  for (genvar l = 0; l <= N; l++) begin : g_st
    logic                 c_valid, p_valid;
    logic [MW-1:0]        c_meta, p_meta;
    logic [W-1:0]         c_rem, p_rem;
    logic [W-1:0]         c_quo, p_quo;
    logic [K-1:0][RW-1:0] c_mul, p_mul;

    if (l == 0) begin : g_pre
      logic         a_neg, b_neg;
      logic [W-1:0] a_mag, b_mag;

      // Signed modes divide magnitudes; MIN negates to 2^(W-1) as unsigned
      always_comb begin
        a_neg   = ~mode[0] & rs1[W-1];
        b_neg   = ~mode[0] & rs2[W-1];
        a_mag   = a_neg ? -rs1 : rs1;
        b_mag   = b_neg ? -rs2 : rs2;
        c_valid = accepted;
        c_meta  = {mode[1], (rs2 == '0), a_neg, a_neg ^ b_neg, rs1, pa_rd_in};
        c_rem   = '0;
        c_quo   = a_mag;
        c_mul   = '0;
        for (int unsigned j = 1; j <= K; j++) begin
          c_mul[j-1] = RW'(j) * RW'(b_mag);
        end
      end
    end else begin : g_div
      logic [RW-1:0]   cur, sub;
      logic [BASE-1:0] k;

      // Pick the largest multiple that fits; a zero divisor resolves digit 0
      always_comb begin
        c_valid = g_st[l-1].p_valid;
        c_meta  = g_st[l-1].p_meta;
        c_mul   = g_st[l-1].p_mul;
        cur     = {g_st[l-1].p_rem, g_st[l-1].p_quo[W-1 -: BASE]};
        k       = '0;
        sub     = '0;
        for (int unsigned j = 1; j <= K; j++) begin
          if ((g_st[l-1].p_mul[j-1] != '0) && (cur >= g_st[l-1].p_mul[j-1])) begin
            k   = BASE'(j);
            sub = g_st[l-1].p_mul[j-1];
          end
        end
        c_rem = W'(cur - sub);
        c_quo = W'({g_st[l-1].p_quo, k});
      end
    end

    if ((l % PERIOD) == 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= 1'b0;
          p_meta  <= '0;
          p_rem   <= '0;
          p_quo   <= '0;
          p_mul   <= '0;
        end else begin
          p_valid <= c_valid & ~flush;
          if (c_valid) begin
            p_meta <= c_meta;
            p_rem  <= c_rem;
            p_quo  <= c_quo;
            p_mul  <= c_mul;
          end
        end
      end
    end else begin : g_thru
      assign p_valid = c_valid;
      assign p_meta  = c_meta;
      assign p_rem   = c_rem;
      assign p_quo   = c_quo;
      assign p_mul   = c_mul;
    end
  end

  logic [MW-1:0] fin_meta;
  logic [W-1:0]  fix_q, fix_r;
  logic          unused_mul;

  assign fin_meta   = g_st[N].p_meta;
  assign unused_mul = ^g_st[N].p_mul;
  assign done       = g_st[N].p_valid;
  assign pa_rd_out  = fin_meta[TAG_W-1:0];

  // Sign restore and divide-by-zero override
  always_comb begin
    fix_q = fin_meta[MW-4] ? -g_st[N].p_quo : g_st[N].p_quo;
    fix_r = fin_meta[MW-3] ? -g_st[N].p_rem : g_st[N].p_rem;
    if (fin_meta[MW-2]) begin
      fix_q = '1;
      fix_r = fin_meta[W+TAG_W-1 -: W];
    end
    rd = fin_meta[MW-1] ? fix_r : fix_q;
  end

endmodule

// File: tb/tb_divrem_pipe.sv
// Bench for divrem_pipe: two configurations share one stimulus stream, each with its
// own expected-result queue built from plain-arithmetic division.
module tb_divrem_pipe;

  localparam int LAT32 = 8 / 3 + 1;
  localparam int LAT16 = 8 / 1 + 1;

  typedef struct {
    int          due;
    logic [31:0] val;
    logic [5:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, order, flush;
  logic [1:0]  mode;
  logic [31:0] rs1, rs2;
  logic [5:0]  tag_in;

  logic        acc32, done32, acc16, done16;
  logic [31:0] rd32;
  logic [15:0] rd16;
  logic [5:0]  pa32, pa16;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  logic x32, x16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divrem_pipe #(.W(32), .BASE(4), .PERIOD(3), .TAG_W(6)) u_d32 (
    .clk(clk), .rst(rst), .order(order), .accepted(acc32), .done(done32),
    .rs1(rs1), .rs2(rs2), .mode(mode), .flush(flush), .pa_rd_in(tag_in),
    .rd(rd32), .pa_rd_out(pa32)
  );

  divrem_pipe #(.W(16), .BASE(2), .PERIOD(1), .TAG_W(6)) u_d16 (
    .clk(clk), .rst(rst), .order(order), .accepted(acc16), .done(done16),
    .rs1(rs1[15:0]), .rs2(rs2[15:0]), .mode(mode), .flush(flush), .pa_rd_in(tag_in),
    .rd(rd16), .pa_rd_out(pa16)
  );

  // RISC-V M-extension semantics at width w, using host integer arithmetic
  function automatic logic [31:0] ref_model(input int w, input logic [1:0] m,
                                            input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub;
    longint sa, sb, res;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (ub == 0) return m[1] ? a & 32'(mask) : 32'(mask);
    if (m[0]) begin
      res = m[1] ? longint'(ua % ub) : longint'(ua / ub);
    end else begin
      sa = longint'(ua) - ((((ua >> (w - 1)) & 64'd1) != 0) ? longint'(64'd1 << w) : 64'sd0);
      sb = longint'(ub) - ((((ub >> (w - 1)) & 64'd1) != 0) ? longint'(64'd1 << w) : 64'sd0);
      res = m[1] ? sa % sb : sa / sb;
    end
    return 32'(longint'(res) & longint'(mask));
  endfunction

  // One cycle of stimulus; updates the expected queues and checks accepted
  task automatic step(input logic r, input logic fl, input logic ord, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    exp_t e;
    logic exp_acc;
    @(posedge clk);
    #1;
    rst = r; flush = fl; order = ord; mode = m; rs1 = a; rs2 = b; tag_in = t;
    exp_acc = ord & ~fl & ~r;
    if (fl | r) begin
      while (q32.size() > 0 && q32[$].due > cyc) void'(q32.pop_back());
      while (q16.size() > 0 && q16[$].due > cyc) void'(q16.pop_back());
    end
    if (exp_acc) begin
      e.tag = t;
      e.due = cyc + LAT32; e.val = ref_model(32, m, a, b); q32.push_back(e);
      e.due = cyc + LAT16; e.val = ref_model(16, m, a, b); q16.push_back(e);
    end
    #1;
    checks++;
    assert (acc32 === exp_acc) else begin
      errors++; $error("FAIL accepted32 cyc=%0d got=%b exp=%b", cyc, acc32, exp_acc);
    end
    checks++;
    assert (acc16 === exp_acc) else begin
      errors++; $error("FAIL accepted16 cyc=%0d got=%b exp=%b", cyc, acc16, exp_acc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 6'd0);
  endtask

  task automatic op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                    input logic [5:0] t);
    step(1'b0, 1'b0, 1'b1, m, a, b, t);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    assert ({done32, rd32, pa32} === 39'd0) else begin
      errors++; $error("FAIL %s_32 got done=%b rd=%h tag=%0d exp all 0", nm, done32, rd32, pa32);
    end
    checks++;
    assert ({done16, rd16, pa16} === 23'd0) else begin
      errors++; $error("FAIL %s_16 got done=%b rd=%h tag=%0d exp all 0", nm, done16, rd16, pa16);
    end
  endtask

  // Completion monitors: done must fire exactly on the due cycle of the oldest op
  always @(negedge clk) if (mon_en) begin
    x32 = (q32.size() > 0) && (q32[0].due == cyc);
    checks++;
    assert (done32 === x32) else begin
      errors++; $error("FAIL done32 cyc=%0d got=%b exp=%b", cyc, done32, x32);
    end
    if (x32) begin
      e32 = q32.pop_front();
      checks++;
      assert (rd32 === e32.val) else begin
        errors++; $error("FAIL rd32 cyc=%0d got=%h exp=%h", cyc, rd32, e32.val);
      end
      checks++;
      assert (pa32 === e32.tag) else begin
        errors++; $error("FAIL tag32 cyc=%0d got=%0d exp=%0d", cyc, pa32, e32.tag);
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    x16 = (q16.size() > 0) && (q16[0].due == cyc);
    checks++;
    assert (done16 === x16) else begin
      errors++; $error("FAIL done16 cyc=%0d got=%b exp=%b", cyc, done16, x16);
    end
    if (x16) begin
      e16 = q16.pop_front();
      checks++;
      assert (rd16 === e16.val[15:0]) else begin
        errors++; $error("FAIL rd16 cyc=%0d got=%h exp=%h", cyc, rd16, e16.val[15:0]);
      end
      checks++;
      assert (pa16 === e16.tag) else begin
        errors++; $error("FAIL tag16 cyc=%0d got=%0d exp=%0d", cyc, pa16, e16.tag);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; order = 1'b0; mode = 2'b00;
    rs1 = '0; rs2 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    mon_en = 1'b1;
    idle(2);

    // basic unsigned
    op(2'b01, 32'd100, 32'd7, 6'd5);
    op(2'b11, 32'd100, 32'd7, 6'd6);
    idle(3);
    // signed
    op(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd7);
    op(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd8);
    op(2'b00, 32'd7, 32'hFFFF_FFFE, 6'd9);
    // divide by zero
    op(2'b01, 32'd5, 32'd0, 6'd10);
    op(2'b00, 32'hFFFF_FFFB, 32'd0, 6'd11);
    op(2'b10, 32'hFFFF_FFFB, 32'd0, 6'd12);
    op(2'b11, 32'd5, 32'd0, 6'd13);
    // overflow and its unsigned counterpart
    op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14);
    op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15);
    op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16);
    op(2'b00, 32'h0000_8000, 32'h0000_FFFF, 6'd17);
    idle(12);

    // ten back-to-back random ops, tags 0..9
    for (int i = 0; i < 10; i++)
      op(2'($urandom), $urandom, $urandom >> $urandom_range(0, 31), 6'(i));
    idle(12);

    // random ops with random gaps
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
           $urandom >> $urandom_range(0, 31), 6'($urandom));
    idle(12);

    // flush kills in-flight ops and refuses the same-cycle order
    op(2'b01, 32'd1000, 32'd3, 6'd20);
    op(2'b01, 32'd2000, 32'd3, 6'd21);
    step(1'b0, 1'b1, 1'b1, 2'b01, 32'd3000, 32'd3, 6'd22);
    op(2'b01, 32'd4000, 32'd3, 6'd23);
    idle(12);

    // reset mid-flight behaves like flush and zeroes the outputs
    op(2'b00, 32'hFFFF_0000, 32'd5, 6'd30);
    op(2'b10, 32'hFFFF_0000, 32'd5, 6'd31);
    step(1'b1, 1'b0, 1'b1, 2'b01, 32'd77, 32'd5, 6'd32);
    op(2'b01, 32'd77, 32'd5, 6'd33);
    check_zero("post_rst");
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
